sys_cmd_ctrl: RTL and testbench

Command sequencer between the UART receive path and the system resources. It consumes the byte stream delivered by the UART receiver (parallel byte plus one-cycle valid) and decodes framed commands. It then sequences register-file writes and reads and ALU operations, and returns results byte-wise to the UART transmit FIFO. Single clock domain, placed in the reference-clock domain after the RX data synchronizer.

---
 rtl/sys_cmd_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: decodes framed UART commands into register-file and ALU
// operations and streams responses byte-wise to the TX FIFO.
module sys_cmd_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int TIMEOUT       = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
    input  logic                     RF_RD_DATA_VLD,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    input  logic                     TX_FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]    RF_ADDR,
    output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
    output logic                     RF_WR_EN,
    output logic                     RF_RD_EN,
    output logic [3:0]               ALU_FUN,
    output logic                     ALU_EN,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     CMD_ERR
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_ADDR  = 4'd1,
        S_WR_DATA  = 4'd2,
        S_RD_ADDR  = 4'd3,
        S_RD_WAIT  = 4'd4,
        S_ALU_OPA  = 4'd5,
        S_ALU_OPB  = 4'd6,
        S_ALU_FUN  = 4'd7,
        S_ALU_WAIT = 4'd8,
        S_TX_LSB   = 4'd9,
        S_TX_MSB   = 4'd10
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    timeout_s;
    logic                    resp_alu_q;
    logic [DATA_WIDTH-1:0]   msb_q;
    logic [ADDR_WIDTH-1:0]   rf_addr_q;
    logic [DATA_WIDTH-1:0]   rf_wr_data_q;
    logic                    rf_wr_en_q;
    logic                    rf_rd_en_q;
    logic [3:0]              alu_fun_q;
    logic                    alu_en_q;
    logic                    gate_q;
    logic [DATA_WIDTH-1:0]   tx_data_q;
    logic                    tx_vld_q;
    logic                    err_q;

    // Wait-state counter increment and expiry detect
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        timeout_s = (cnt_d == TO_VAL);
    end

    // Frame decoder FSM with registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            resp_alu_q   <= 1'b0;
            msb_q        <= '0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            alu_fun_q    <= 4'd0;
            alu_en_q     <= 1'b0;
            gate_q       <= 1'b0;
            tx_data_q    <= '0;
            tx_vld_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rf_wr_en_q <= 1'b0;
            rf_rd_en_q <= 1'b0;
            alu_en_q   <= 1'b0;
            tx_vld_q   <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            CMD_WR:  state_q <= S_WR_ADDR;
                            CMD_RD:  state_q <= S_RD_ADDR;
                            CMD_ALU: state_q <= S_ALU_OPA;
                            CMD_FUN: state_q <= S_ALU_FUN;
                            default: err_q   <= 1'b1;
                        endcase
                    end
                end
                S_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        rf_addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state_q   <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (RX_D_VLD) begin
                        rf_wr_data_q <= RX_P_DATA;
                        rf_wr_en_q   <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        rf_addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        rf_rd_en_q <= 1'b1;
                        resp_alu_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // A valid on the expiry cycle takes priority over the timeout
                    if (RF_RD_DATA_VLD) begin
                        tx_data_q <= RF_RD_DATA;
                        if (!TX_FIFO_FULL) begin
                            tx_vld_q <= 1'b1;
                            state_q  <= S_IDLE;
                        end else begin
                            state_q  <= S_TX_LSB;
                        end
                    end else if (timeout_s) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_ALU_OPA: begin
                    if (RX_D_VLD) begin
                        rf_addr_q    <= ADDR_WIDTH'(0);
                        rf_wr_data_q <= RX_P_DATA;
                        rf_wr_en_q   <= 1'b1;
                        state_q      <= S_ALU_OPB;
                    end
                end
                S_ALU_OPB: begin
                    if (RX_D_VLD) begin
                        rf_addr_q    <= ADDR_WIDTH'(1);
                        rf_wr_data_q <= RX_P_DATA;
                        rf_wr_en_q   <= 1'b1;
                        state_q      <= S_ALU_FUN;
                    end
                end
                S_ALU_FUN: begin
                    if (RX_D_VLD) begin
                        alu_fun_q  <= RX_P_DATA[3:0];
                        alu_en_q   <= 1'b1;
                        gate_q     <= 1'b1;
                        resp_alu_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_ALU_WAIT;
                    end
                end
                S_ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        gate_q    <= 1'b0;
                        tx_data_q <= ALU_OUT[DATA_WIDTH-1:0];
                        msb_q     <= ALU_OUT[ALU_OUT_WIDTH-1 -: DATA_WIDTH];
                        if (!TX_FIFO_FULL) begin
                            tx_vld_q <= 1'b1;
                            state_q  <= S_TX_MSB;
                        end else begin
                            state_q  <= S_TX_LSB;
                        end
                    end else if (timeout_s) begin
                        err_q   <= 1'b1;
                        gate_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_TX_LSB: begin
                    if (!TX_FIFO_FULL) begin
                        tx_vld_q <= 1'b1;
                        state_q  <= resp_alu_q ? S_TX_MSB : S_IDLE;
                    end
                end
                S_TX_MSB: begin
                    // Entered while the LSB push is on the bus; MSB follows once not full
                    if (!TX_FIFO_FULL) begin
                        tx_vld_q  <= 1'b1;
                        tx_data_q <= msb_q;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign RF_ADDR     = rf_addr_q;
    assign RF_WR_DATA  = rf_wr_data_q;
    assign RF_WR_EN    = rf_wr_en_q;
    assign RF_RD_EN    = rf_rd_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign ALU_EN      = alu_en_q;
    assign CLK_GATE_EN = gate_q;
    assign TX_P_DATA   = tx_data_q;
    assign TX_D_VLD    = tx_vld_q;
    assign CMD_ERR     = err_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed-vector bench for sys_cmd_ctrl with hand-computed expectations.
module tb_sys_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [7:0]  rf_rd_data;
    logic        rf_rd_vld;
    logic [15:0] alu_out;
    logic        alu_vld;
    logic        tx_full;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic        rf_wr_en;
    logic        rf_rd_en;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic        gate_en;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        cmd_err;

    int n_cmp = 0;
    int n_err = 0;

    sys_cmd_ctrl dut (
        .CLK(clk), .RST(rst),
        .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
        .RF_RD_DATA(rf_rd_data), .RF_RD_DATA_VLD(rf_rd_vld),
        .ALU_OUT(alu_out), .ALU_OUT_VLD(alu_vld),
        .TX_FIFO_FULL(tx_full),
        .RF_ADDR(rf_addr), .RF_WR_DATA(rf_wr_data), .RF_WR_EN(rf_wr_en),
        .RF_RD_EN(rf_rd_en), .ALU_FUN(alu_fun), .ALU_EN(alu_en),
        .CLK_GATE_EN(gate_en), .TX_P_DATA(tx_data), .TX_D_VLD(tx_vld),
        .CMD_ERR(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; afterwards outputs reflect the edge just taken
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        step();
        rx_vld  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_vld = 1'b0;
        rf_rd_data = 8'h00; rf_rd_vld = 1'b0;
        alu_out = 16'h0000; alu_vld = 1'b0; tx_full = 1'b0;
        step();
        step();
        check_val("rst_strobes", {26'd0, rf_wr_en, rf_rd_en, alu_en, gate_en, tx_vld, cmd_err}, 32'd0);
        check_val("rst_data", {4'd0, rf_addr, rf_wr_data, alu_fun, tx_data}, 32'd0);
        rst = 1'b0;
        step();

        // Write frame with idle gaps
        send_byte(8'hAA);
        check_val("wr_no_early_en0", {31'd0, rf_wr_en}, 32'd0);
        step();
        send_byte(8'h05);
        check_val("wr_no_early_en1", {31'd0, rf_wr_en}, 32'd0);
        step();
        send_byte(8'h3C);
        check_val("wr_en", {31'd0, rf_wr_en}, 32'd1);
        check_val("wr_addr", {28'd0, rf_addr}, 32'h5);
        check_val("wr_data", {24'd0, rf_wr_data}, 32'h3C);
        check_val("wr_no_tx", {31'd0, tx_vld}, 32'd0);
        step();
        check_val("wr_en_pulse", {31'd0, rf_wr_en}, 32'd0);
        check_val("wr_addr_hold", {28'd0, rf_addr}, 32'h5);

        // Read frame, valid three cycles after the read strobe
        send_byte(8'hBB);
        send_byte(8'h1A);
        check_val("rd_en", {31'd0, rf_rd_en}, 32'd1);
        check_val("rd_addr", {28'd0, rf_addr}, 32'hA);
        step();
        check_val("rd_en_pulse", {31'd0, rf_rd_en}, 32'd0);
        step();
        step();
        rf_rd_data = 8'h7E; rf_rd_vld = 1'b1;
        step();
        rf_rd_vld = 1'b0;
        check_val("rd_tx_vld", {31'd0, tx_vld}, 32'd1);
        check_val("rd_tx_data", {24'd0, tx_data}, 32'h7E);
        step();
        check_val("rd_tx_single", {31'd0, tx_vld}, 32'd0);

        // ALU frame with operands
        send_byte(8'hCC);
        send_byte(8'h12);
        check_val("alu_opa_en", {31'd0, rf_wr_en}, 32'd1);
        check_val("alu_opa_addr", {28'd0, rf_addr}, 32'h0);
        check_val("alu_opa_data", {24'd0, rf_wr_data}, 32'h12);
        send_byte(8'h34);
        check_val("alu_opb_en", {31'd0, rf_wr_en}, 32'd1);
        check_val("alu_opb_addr", {28'd0, rf_addr}, 32'h1);
        check_val("alu_opb_data", {24'd0, rf_wr_data}, 32'h34);
        send_byte(8'h01);
        check_val("alu_en", {31'd0, alu_en}, 32'd1);
        check_val("alu_fun", {28'd0, alu_fun}, 32'h1);
        check_val("alu_gate_on", {31'd0, gate_en}, 32'd1);
        check_val("alu_no_wr", {31'd0, rf_wr_en}, 32'd0);
        step();
        check_val("alu_en_pulse", {31'd0, alu_en}, 32'd0);
        check_val("alu_gate_wait", {31'd0, gate_en}, 32'd1);
        step();
        alu_out = 16'h0046; alu_vld = 1'b1;
        step();
        alu_vld = 1'b0;
        check_val("alu_tx_lsb_vld", {31'd0, tx_vld}, 32'd1);
        check_val("alu_tx_lsb", {24'd0, tx_data}, 32'h46);
        step();
        check_val("alu_tx_msb_vld", {31'd0, tx_vld}, 32'd1);
        check_val("alu_tx_msb", {24'd0, tx_data}, 32'h00);
        step();
        check_val("alu_tx_done", {31'd0, tx_vld}, 32'd0);
        check_val("alu_gate_off", {31'd0, gate_en}, 32'd0);

        // ALU without operands, TX FIFO full for five cycles after the result
        send_byte(8'hDD);
        send_byte(8'h02);
        check_val("dd_alu_en", {31'd0, alu_en}, 32'd1);
        check_val("dd_fun", {28'd0, alu_fun}, 32'h2);
        step();
        alu_out = 16'h1234; alu_vld = 1'b1; tx_full = 1'b1;
        step();
        alu_vld = 1'b0;
        check_val("full_no_vld", {31'd0, tx_vld}, 32'd0);
        check_val("full_data", {24'd0, tx_data}, 32'h34);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("full_hold_vld", {31'd0, tx_vld}, 32'd0);
            check_val("full_hold_data", {24'd0, tx_data}, 32'h34);
        end
        tx_full = 1'b0;
        step();
        check_val("rel_lsb_vld", {31'd0, tx_vld}, 32'd1);
        check_val("rel_lsb", {24'd0, tx_data}, 32'h34);
        step();
        check_val("rel_msb_vld", {31'd0, tx_vld}, 32'd1);
        check_val("rel_msb", {24'd0, tx_data}, 32'h12);
        step();
        check_val("rel_done", {31'd0, tx_vld}, 32'd0);

        // Unknown command byte
        send_byte(8'h55);
        check_val("bad_cmd_err", {31'd0, cmd_err}, 32'd1);
        step();
        check_val("bad_cmd_pulse", {31'd0, cmd_err}, 32'd0);

        // Read timeout: error exactly TIMEOUT cycles after entering the wait
        send_byte(8'hBB);
        send_byte(8'h03);
        check_val("to_rd_en", {31'd0, rf_rd_en}, 32'd1);
        check_val("to_rd_addr", {28'd0, rf_addr}, 32'h3);
        for (int i = 1; i <= 16; i++) begin
            step();
            check_val("to_err", {31'd0, cmd_err}, {31'd0, (i == 16)});
        end
        step();
        check_val("to_err_pulse", {31'd0, cmd_err}, 32'd0);

        // Valid on the expiry cycle wins over the timeout
        send_byte(8'hBB);
        send_byte(8'h04);
        for (int i = 0; i < 15; i++) begin
            step();
        end
        rf_rd_data = 8'h99; rf_rd_vld = 1'b1;
        step();
        rf_rd_vld = 1'b0;
        check_val("edge_tx_vld", {31'd0, tx_vld}, 32'd1);
        check_val("edge_tx_data", {24'd0, tx_data}, 32'h99);
        check_val("edge_no_err", {31'd0, cmd_err}, 32'd0);
        step();
        check_val("edge_no_err_late", {31'd0, cmd_err}, 32'd0);

        // Reset mid-frame, then a clean write frame
        send_byte(8'hCC);
        send_byte(8'hAB);
        check_val("pre_rst_wr_en", {31'd0, rf_wr_en}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("mid_rst_strobes", {26'd0, rf_wr_en, rf_rd_en, alu_en, gate_en, tx_vld, cmd_err}, 32'd0);
        check_val("mid_rst_data", {4'd0, rf_addr, rf_wr_data, alu_fun, tx_data}, 32'd0);
        send_byte(8'hAA);
        check_val("post_rst_no_wr", {31'd0, rf_wr_en}, 32'd0);
        send_byte(8'h01);
        send_byte(8'hFF);
        check_val("post_rst_wr_en", {31'd0, rf_wr_en}, 32'd1);
        check_val("post_rst_addr", {28'd0, rf_addr}, 32'h1);
        check_val("post_rst_data", {24'd0, rf_wr_data}, 32'hFF);
        check_val("post_rst_no_err", {31'd0, cmd_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
